// File: rtl/fifo_reader.sv
// Pulls words from an upstream FIFO into a 3-entry skid buffer and presents them as a valid/ready stream.
// Optional delivered-word counter enabled by defining FIFO_READER_CNT_EN.
module fifo_reader #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  EMP,
    output logic                  read_req,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [15:0]           word_count
);

    localparam int unsigned DEPTH = 3;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 16;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      occ;
    logic                  pend;
    logic                  push;
    logic                  pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Request only while the buffer plus the word in flight leaves a free slot.
    assign read_req  = !reset && !EMP && !flush &&
                       ((3'({1'b0, occ}) + 3'({2'b00, pend})) < 3'(DEPTH));
    assign push      = pend && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign out_valid = (occ != '0);
    assign out_data  = mem[rd_ptr];
    assign busy      = (occ != '0) || pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            pend   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            pend   <= 1'b0;
        end else begin
            pend <= read_req;
            if (push) begin
                mem[wr_ptr] <= read_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + PTR_W'(1);
                2'b01:   occ <= occ - PTR_W'(1);
                default: occ <= occ;
            endcase
        end
    end

`ifdef FIFO_READER_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Counts accepted output words; wraps naturally at 2^16.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (pop) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign word_count = cnt;
`else
    assign word_count = '0;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && (occ == PTR_W'(DEPTH))));

    a_no_req_when_empty: assert property (@(posedge clk) disable iff (reset)
        !(read_req && EMP));

endmodule

// File: tb/tb_fifo_reader.sv
// Randomized and directed bench for fifo_reader against a queue-based model of the upstream FIFO and skid buffer.
module tb_fifo_reader;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          EMP;
    logic          read_req;
    logic [DW-1:0] read_data;
    logic          flush;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          busy;
    logic [15:0]   word_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] src[$];
    logic [DW-1:0] inflight[$];
    logic [DW-1:0] held[$];
    logic [DW-1:0] got[$];
    logic [15:0]   cnt = '0;
    int            pops_total = 0;
    int            rr_pulses = 0;
    bit            emp_force = 1'b0;

    always #5 clk = ~clk;

    fifo_reader #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .EMP        (EMP),
        .read_req   (read_req),
        .read_data  (read_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .word_count (word_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_wc();
`ifdef FIFO_READER_CNT_EN
        return cnt;
`else
        return 16'h0;
`endif
    endfunction

    // One clock cycle: drive at posedge+1, check at negedge, advance the model at posedge.
    task automatic cycle(input bit rdy, input bit fl);
        bit exp_rr;
        bit exp_ov;
        out_ready = rdy;
        flush     = fl;
        EMP       = (src.size() == 0) || emp_force;
        @(negedge clk);
        exp_rr = !EMP && !fl && ((held.size() + inflight.size()) < 3);
        exp_ov = (held.size() != 0);
        check("read_req", 32'(read_req), 32'(exp_rr));
        check("req_while_emp", 32'(read_req && EMP), 32'(0));
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("busy", 32'(busy), 32'((held.size() != 0) || (inflight.size() != 0)));
        if (exp_ov) check("out_data", 32'(out_data), 32'(held[0]));
        check("word_count", 32'(word_count), 32'(exp_wc()));
        if (exp_rr) rr_pulses++;
        @(posedge clk);
        if (fl) begin
            held.delete();
            inflight.delete();
            cnt = '0;
        end else begin
            if (exp_ov && rdy) begin
                got.push_back(held.pop_front());
                cnt = cnt + 16'd1;
                pops_total++;
            end
            if (inflight.size() != 0) held.push_back(inflight.pop_front());
            if (exp_rr) inflight.push_back(src.pop_front());
        end
        #1;
        read_data = (inflight.size() != 0) ? inflight[0] : DW'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_read_req", 32'(read_req), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_word_count", 32'(word_count), 32'(0));
        held.delete();
        inflight.delete();
        src.delete();
        got.delete();
        cnt = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] first;
        reset     = 1'b1;
        EMP       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        read_data = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Five words with out_ready high: two-cycle latency, then back-to-back delivery.
        for (int i = 1; i <= 5; i++) src.push_back(DW'(i));
        cycle(1, 0);
        cycle(1, 0);
        check("latency_valid", 32'(out_valid), 32'(1));
        check("latency_data", 32'(out_data), 32'(8'h01));
        for (int i = 0; i < 8; i++) cycle(1, 0);
        check("seq5_count", 32'(got.size()), 32'(5));
        for (int i = 0; i < 5 && i < got.size(); i++) check("seq5_word", 32'(got[i]), 32'(i + 1));
        check("seq5_idle_busy", 32'(busy), 32'(0));

        // Ten words with out_ready low: only three reads, head word held.
        got.delete();
        for (int i = 0; i < 10; i++) src.push_back(DW'(8'h40 + i));
        rr_pulses = 0;
        for (int i = 0; i < 8; i++) cycle(0, 0);
        check("stall_rr_pulses", 32'(rr_pulses), 32'(3));
        check("stall_held", 32'(held.size()), 32'(3));
        first = out_data;
        check("stall_head", 32'(first), 32'(8'h40));
        for (int i = 0; i < 15; i++) cycle(1, 0);
        check("stall_count", 32'(got.size()), 32'(10));
        for (int i = 0; i < 10 && i < got.size(); i++) check("stall_word", 32'(got[i]), 32'(8'h40 + i));

        // Flush with two buffered words and one in flight.
        got.delete();
        for (int i = 0; i < 8; i++) src.push_back(DW'(8'h80 + i));
        for (int i = 0; i < 3; i++) cycle(0, 0);
        check("pre_flush_held", 32'(held.size()), 32'(2));
        check("pre_flush_inflight", 32'(inflight.size()), 32'(1));
        cycle(0, 1);
        check("post_flush_valid", 32'(out_valid), 32'(0));
        check("post_flush_busy", 32'(busy), 32'(0));
        for (int i = 0; i < 10; i++) cycle(1, 0);
        check("flush_count", 32'(got.size()), 32'(5));
        for (int i = 0; i < 5 && i < got.size(); i++) check("flush_word", 32'(got[i]), 32'(8'h83 + i));

        // Random EMP toggling, random ready and occasional flush.
        got.delete();
        for (int i = 0; i < 200; i++) src.push_back(DW'($urandom));
        for (int i = 0; i < 400; i++) begin
            emp_force = ~emp_force;
            cycle(bit'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
        end
        emp_force = 1'b0;
        for (int i = 0; i < 300 && src.size() != 0; i++) cycle(1, 0);
        for (int i = 0; i < 6; i++) cycle(1, 0);
        check("rand_drained", 32'(busy), 32'(0));

        // Reset mid-stream with a full buffer, then fresh words from the first one.
        for (int i = 0; i < 6; i++) src.push_back(DW'(8'hA0 + i));
        for (int i = 0; i < 5; i++) cycle(0, 0);
        check("pre_rst_held", 32'(held.size()), 32'(3));
        do_reset();
        for (int i = 0; i < 4; i++) src.push_back(DW'(8'hC0 + i));
        for (int i = 0; i < 8; i++) cycle(1, 0);
        check("rst_fresh_count", 32'(got.size()), 32'(4));
        for (int i = 0; i < 4 && i < got.size(); i++) check("rst_fresh_word", 32'(got[i]), 32'(8'hC0 + i));

`ifdef FIFO_READER_CNT_EN
        // Counter wrap: 65537 pops leaves a count of one.
        do_reset();
        pops_total = 0;
        for (int i = 0; i < 65540; i++) src.push_back(DW'(i));
        for (int i = 0; i < 66000 && pops_total < 65537; i++) begin
            cycle(1, 0);
            if (got.size() > 4) void'(got.pop_front());
        end
        check("wrap_pops", 32'(pops_total), 32'(65537));
        check("wrap_count", 32'(word_count), 32'(1));
        cycle(0, 1);
        check("flush_clears_count", 32'(word_count), 32'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
